data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
//  Data memory stage directly downstream of the ALU in the single-cycle MIPS datapath.
//  - aluout (effective address) is the address input.
//  - Performs sw/sh/sb stores on the clock edge.
//  - Performs lw/lh/lhu/lb/lbu loads combinationally, with sign or zero extension.
//  - Flags misaligned or illegal accesses and records them in a sticky fault register.
// PARAMETERS
//  WORDS_LOG2  10  log2 of memory depth in 32-bit words (default 1024 words = 4 KiB)
// PORTS
//  clk       in   1   system clock; all state updates on posedge
//  rst_n     in   1   asynchronous, active-low reset
//  addr      in   32  byte address from ALU aluout
//  wdata     in   32  store data (rt register value)
//  we        in   1   store enable (MemWrite)
//  re        in   1   load enable (MemRead)
//  size      in   2   access size: 00 byte, 01 half, 10 word, 11 reserved
//  sign_ext  in   1   1: sign-extend byte/half loads; 0: zero-extend
//  rdata     out  32  load result
//  misalign  out  1   combinational: current access is misaligned or illegal
//  fault     out  1   sticky registered fault flag
//  wr_cnt    out  32  count of committed stores (debug)
// BEHAVIOUR
//  Reset (rst_n=0, async, dominates clk)
//   - all memory words = 0; fault = 0; wr_cnt = 0
//   - rdata therefore reads 0
//   - reset asserted mid-cycle aborts any store pending for the next edge
//  Address
//   - word index = addr[WORDS_LOG2+1:2]; higher address bits ignored (wrap-around)
//   - 0x0000_1000 aliases 0x0 at default depth
//  Byte lanes
//   - little-endian: addr[1:0]=0 selects bits 7:0; addr[1]=1 selects half bits 31:16
//  Alignment
//   - illegal when (size=01 & addr[0]) | (size=10 & addr[1:0]!=0) | size=11
//   - misalign = (we|re) & illegal; combinational, same cycle
//  Store
//   - at posedge when we & ~misalign
//   - writes only the selected lanes (1, 2 or 4 bytes); other lanes unchanged
//   - wr_cnt += 1, wrapping at 2^32
//  Load (combinational, zero latency)
//   - if re & ~misalign: rdata = selected lane(s), extended per sign_ext
//   - size=10 ignores sign_ext
//   - otherwise rdata = 0
//  Read-during-write to the same word: rdata shows OLD contents until the edge
//  Simultaneous we & re: legal; store commits at edge, load returns pre-edge data
//  Fault
//   - set at posedge when misalign = 1; held until rst_n low
//   - no state other than fault changes on a misaligned store
// STRUCTURE
//  Shared header mips_defs.v
//   - `SZ_BYTE=2'b00, `SZ_HALF=2'b01, `SZ_WORD=2'b10
//   - the same size codes the control unit emits
//  Sub-module dm_load_ext (combinational)
//   - inputs: word, addr[1:0], size, sign_ext; output: 32-bit extended result
//  Top level holds the array, lane-merge write logic, fault register and wr_cnt
// TESTING
//  1. rst_n=0 then 1; re=1, size=10, addr=0x10 -> rdata=0, fault=0, wr_cnt=0
//  2. we, size=10, addr=0x20, wdata=0x8899AABB; then re -> rdata=0x8899AABB, wr_cnt=1
//  3. sb addr=0x21, wdata=0x000000FF over test 2's word
//     -> word=0x8899FFBB
//     -> lb 0x21 sign_ext=1: rdata=0xFFFFFFFF; lbu: 0x000000FF
//  4. lh addr=0x22 sign_ext=1 on 0x8899FFBB -> 0xFFFF8899; lhu -> 0x00008899
//  5. sw addr=0x22 (misaligned)
//     -> misalign=1 same cycle; memory unchanged; fault=1 after edge, stays 1; wr_cnt unchanged
//  6. sw addr=0x1004, wdata=5 -> lw 0x4 returns 5 (wrap)
//     - assert rst_n mid-cycle with we=1 -> no write; fault, wr_cnt, memory = 0

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory stage: access size codes and lane/alignment helpers.
// The size codes match those emitted by the control unit.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size_e'(size))
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte-lane enables for a store; only meaningful for legal accesses.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size_e'(size))
            SZ_BYTE: mask = 4'b0001 << lo;
            SZ_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load-path lane selection with sign or zero extension of byte and half loads.
module dm_load_ext
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_sel,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (byte_sel)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = 8'h00;
        endcase
        sel_half = byte_sel[1] ? word[31:16] : word[15:0];

        result = 32'h0;
        case (size_e'(size))
            SZ_BYTE: result = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            SZ_HALF: result = {{16{sign_ext & sel_half[15]}}, sel_half};
            SZ_WORD: result = word;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Data memory stage of the single-cycle MIPS datapath: byte-lane stores on the clock edge,
// combinational extended loads, and a sticky fault flag for misaligned or illegal accesses.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        fault,
    output logic [31:0] wr_cnt
);

    localparam int DEPTH = 1 << WORDS_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [WORDS_LOG2-1:0] word_idx;
    logic [31:0]           cur_word;
    logic [31:0]           ext_data;
    logic [3:0]            lane_en;
    logic [31:0]           lane_data;
    logic                  unused_addr_bits;

    // Address bits above the array depth are ignored, so the memory wraps around.
    assign word_idx         = addr[WORDS_LOG2+1:2];
    assign unused_addr_bits = ^addr[31:WORDS_LOG2+2];
    assign cur_word         = mem[word_idx];

    assign misalign = (we | re) & is_illegal(size, addr[1:0]);

    always_comb begin
        lane_en   = lane_mask(size, addr[1:0]);
        lane_data = wdata;
        case (size_e'(size))
            SZ_BYTE: lane_data = {4{wdata[7:0]}};
            SZ_HALF: lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    end

    dm_load_ext u_load_ext (
        .word     (cur_word),
        .byte_sel (addr[1:0]),
        .size     (size),
        .sign_ext (sign_ext),
        .result   (ext_data)
    );

    assign rdata = (re & ~misalign) ? ext_data : 32'h0;

    // A misaligned access only raises fault; memory and wr_cnt are left untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
            fault  <= 1'b0;
            wr_cnt <= 32'h0;
        end else begin
            if (misalign) begin
                fault <= 1'b1;
            end
            if (we && !misalign) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_en[b]) begin
                        mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
                    end
                end
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios followed by randomized traffic
// compared against a byte-array reference model.
module tb_data_mem;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] rdata;
    logic        misalign;
    logic        fault;
    logic [31:0] wr_cnt;

    int          n_checks;
    int          n_errors;

    logic [7:0]  mdl_mem [4096];
    logic        mdl_fault;
    logic [31:0] mdl_cnt;

    data_mem dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .size     (size),
        .sign_ext (sign_ext),
        .rdata    (rdata),
        .misalign (misalign),
        .fault    (fault),
        .wr_cnt   (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic void modelClear();
        for (int i = 0; i < 4096; i++) mdl_mem[i] = 8'h00;
        mdl_fault = 1'b0;
        mdl_cnt   = 32'h0;
    endfunction

    function automatic int nBytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit modelIllegal(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd3) return 1'b1;
        return (a % nBytes(s)) != 0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] s,
                                              input bit sx);
        longint v;
        int     base;
        int     n;
        base = int'(a % 4096);
        n    = nBytes(s);
        v    = 0;
        for (int k = n - 1; k >= 0; k--) v = v * 256 + mdl_mem[base + k];
        if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    function automatic void modelStore(input logic [31:0] a, input logic [1:0] s,
                                       input logic [31:0] d);
        int          base;
        logic [31:0] rem;
        base = int'(a % 4096);
        rem  = d;
        for (int k = 0; k < nBytes(s); k++) begin
            mdl_mem[base + k] = rem[7:0];
            rem = rem >> 8;
        end
    endfunction

    // One access cycle: check the combinational outputs before the edge, then state after it.
    task automatic applyStimulus(input bit w, input bit r, input logic [31:0] a,
                                 input logic [31:0] d, input logic [1:0] s, input bit sx);
        bit          exp_mis;
        logic [31:0] exp_rd;
        @(negedge clk);
        we = w; re = r; addr = a; wdata = d; size = s; sign_ext = sx;
        #1;
        exp_mis = (w | r) & modelIllegal(a, s);
        exp_rd  = (r && !exp_mis) ? modelLoad(a, s, sx) : 32'h0;
        checkOutput("misalign", {31'h0, misalign}, {31'h0, exp_mis});
        checkOutput("rdata", rdata, exp_rd);
        @(posedge clk);
        #1;
        if (w && !exp_mis) begin
            modelStore(a, s, d);
            mdl_cnt = mdl_cnt + 32'd1;
        end
        if (exp_mis) mdl_fault = 1'b1;
        checkOutput("fault", {31'h0, fault}, {31'h0, mdl_fault});
        checkOutput("wr_cnt", wr_cnt, mdl_cnt);
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a, input logic [1:0] s,
                             input bit sx, input logic [31:0] lit);
        applyStimulus(1'b0, 1'b1, a, 32'h0, s, sx);
        checkOutput(tag, rdata, lit);
    endtask

    task automatic midReset(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; re = 1'b0; addr = a; wdata = d; size = 2'd2; sign_ext = 1'b0;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;
        modelClear();
        #1;
        checkOutput("rst_fault", {31'h0, fault}, 32'h0);
        checkOutput("rst_wr_cnt", wr_cnt, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        n_checks = 0;
        n_errors = 0;
        modelClear();
        rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0;
        size = 2'd0; sign_ext = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed scenarios");
        readCheck("reset_lw", 32'h10, 2'd2, 1'b0, 32'h0);
        checkOutput("reset_wr_cnt", wr_cnt, 32'h0);

        applyStimulus(1'b1, 1'b0, 32'h20, 32'h8899AABB, 2'd2, 1'b0);
        readCheck("sw_lw", 32'h20, 2'd2, 1'b1, 32'h8899AABB);
        checkOutput("sw_wr_cnt", wr_cnt, 32'd1);

        applyStimulus(1'b1, 1'b0, 32'h21, 32'h000000FF, 2'd0, 1'b0);
        readCheck("sb_word", 32'h20, 2'd2, 1'b0, 32'h8899FFBB);
        readCheck("lb_sx", 32'h21, 2'd0, 1'b1, 32'hFFFFFFFF);
        readCheck("lbu", 32'h21, 2'd0, 1'b0, 32'h000000FF);
        readCheck("lh_sx", 32'h22, 2'd1, 1'b1, 32'hFFFF8899);
        readCheck("lhu", 32'h22, 2'd1, 1'b0, 32'h00008899);

        applyStimulus(1'b1, 1'b0, 32'h22, 32'h12345678, 2'd2, 1'b0);
        checkOutput("mis_fault", {31'h0, fault}, 32'h1);
        checkOutput("mis_wr_cnt", wr_cnt, 32'd2);
        readCheck("mis_unchanged", 32'h20, 2'd2, 1'b0, 32'h8899FFBB);
        checkOutput("fault_sticky", {31'h0, fault}, 32'h1);

        // Simultaneous store and load: load sees pre-edge data.
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h01020304, 2'd2, 1'b0);
        readCheck("rdw_after", 32'h20, 2'd2, 1'b0, 32'h01020304);

        applyStimulus(1'b1, 1'b0, 32'h1004, 32'd5, 2'd2, 1'b0);
        readCheck("wrap_lw", 32'h4, 2'd2, 1'b0, 32'd5);

        midReset(32'h8, 32'hDEADBEEF);
        readCheck("rst_abort", 32'h8, 2'd2, 1'b0, 32'h0);
        readCheck("rst_clear", 32'h4, 2'd2, 1'b0, 32'h0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) midReset($urandom & 32'h0000_003C, $urandom);
            s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom & 32'hFFFF_F03F;
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'd1) a[0] = 1'b0;
                if (s == 2'd2) a[1:0] = 2'b00;
            end
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, s,
                          1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
